serial_word_collector: RTL

//  Downstream consumer of the single-bit registered stage output (q, qualified by en).

---
 rtl/collector_pkg.sv | 13 +
 rtl/out_slot.sv | 53 +++++
 rtl/serial_word_collector.sv | 86 ++++++++
 3 files changed

// File: rtl/collector_pkg.sv
// Shared types and constants for the serial word collector.
package collector_pkg;

  // Framing FSM: waiting for a start bit, or shifting data bits in.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Level of the bit that opens a frame.
  localparam logic START_BIT = 1'b1;

endpackage

// File: rtl/out_slot.sv
// One-entry valid/ready holding register. A word arriving while the slot is
// still full and not being drained is dropped, which raises a sticky overflow.
module out_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overflow
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic             drop;

  // A completed word is lost only if the slot is full and not draining this cycle.
  assign drop = load && valid_q && !ready;

  // Slot contents: load on free or draining slot, clear valid on a plain drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load && (!valid_q || ready)) begin
      data_q  <= word;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/serial_word_collector.sv
// Frames a qualified serial bit stream with a start bit, assembles WIDTH data
// bits MSB-first and hands each word to a one-entry valid/ready output slot.
module serial_word_collector #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_ovf
);

  import collector_pkg::*;

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-2:0] sr_q;
  logic             busy_q;
  logic             word_done;
  logic [WIDTH-1:0] word;

  // The incoming bit completes the word combinationally; the slot registers it.
  assign word      = {sr_q, in_bit};
  assign word_done = (state_q == ST_SHIFT) && in_valid && (cnt_q == CNT_LAST);

  // Framing FSM with bit counter, shift register and registered busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid && (in_bit == START_BIT)) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (in_valid) begin
            sr_q <= word[WIDTH-2:0];
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  out_slot #(
    .WIDTH(WIDTH)
  ) u_out_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (word_done),
    .word     (word),
    .ready    (out_ready),
    .clr_ovf  (clr_ovf),
    .data     (out_data),
    .valid    (out_valid),
    .overflow (overflow)
  );

endmodule
